vector_sequencer: RTL and testbench
===================================

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 The block SHALL have parameter COORD_W, default 12, giving the width of the X and Y coordinates.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the command FIFO depth; DEPTH SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter STEP_X, default 5, giving the pattern X increment.
REQ-004 The block SHALL have parameter STEP_Y, default 10, giving the pattern Y increment.
REQ-005 The block SHALL use one clock, clk, and a synchronous active-high reset, reset.
REQ-006 Port clk: input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 Port reset: input, 1 bit, synchronous, active-high.
REQ-008 Port cmd_valid: input, 1 bit, a command is offered.
REQ-009 Port cmd_ready: output, 1 bit, the FIFO can accept a command.
REQ-010 Port cmd_x: input, COORD_W bits, command X coordinate.
REQ-011 Port cmd_y: input, COORD_W bits, command Y coordinate.
REQ-012 Port cmd_draw: input, 1 bit, 1 = draw a line to the point, 0 = jump to the point.
REQ-013 Port x: output, COORD_W bits, coordinate X presented to the line engine.
REQ-014 Port y: output, COORD_W bits, coordinate Y presented to the line engine.
REQ-015 Port draw: output, 1 bit, one-cycle draw strobe.
REQ-016 Port jump: output, 1 bit, one-cycle jump strobe.
REQ-017 Port ready: input, 1 bit, the line engine is idle.
REQ-018 Port busy: output, 1 bit, a command is in flight.
REQ-019 Port count: output, log2(DEPTH)+1 bits, current FIFO occupancy.
REQ-020 Port pattern_en: input, 1 bit, enables the pattern generator; this port exists only when PATTERN_GEN_EN is defined.

Function
REQ-021 A command SHALL be pushed on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL equal (count != DEPTH), even if a pop occurs in the same cycle.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; the FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo DEPTH.
REQ-023 The FSM SHALL have four states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-024 IDLE: when count > 0 and ready = 1, the block SHALL pop the head entry, load x, y and the entry type, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-025 ISSUE: the block SHALL assert draw (type 1) or jump (type 0) for exactly one cycle, never both, then go to WAIT_ACK.
REQ-026 WAIT_ACK: the block SHALL stay until ready = 0, then go to WAIT_DONE.
REQ-027 WAIT_DONE: the block SHALL stay until ready = 1, then go to IDLE; back-to-back commands SHALL have at least one IDLE cycle between strobes.
REQ-028 x and y SHALL hold their values from load until the next pop.
REQ-029 busy SHALL be 1 in ISSUE, WAIT_ACK and WAIT_DONE, and 0 in IDLE.
REQ-030 Latency: when a command is pushed at edge E into an empty FIFO with ready = 1 and the FSM in IDLE, x and y SHALL update at edge E+2 and the strobe SHALL be high from E+2 to E+3.
REQ-031 A line engine that never drops ready after a strobe SHALL stall the block in WAIT_ACK; this is documented behaviour, not an error.

Reset
REQ-032 While reset = 1 at a clock edge, the block SHALL force state IDLE, count 0 with the FIFO pointers cleared, x = 0, y = 0, draw = 0, jump = 0, busy = 0, and the pattern coordinates to 0.
REQ-033 Reset SHALL take priority over a simultaneous push; a strobe pending or in progress SHALL be dropped, and FIFO contents are lost.
REQ-034 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-035 With macro PATTERN_GEN_EN defined: when pattern_en = 1, cmd_valid = 0 and the FIFO is not full, the generator SHALL push a jump command to (px, py), then update px += STEP_X and py += STEP_Y, modulo 2^COORD_W.
REQ-036 With PATTERN_GEN_EN defined, an external command SHALL always have priority over the generator in the same cycle.
REQ-037 Without PATTERN_GEN_EN: the pattern_en port and the generator logic SHALL be absent, and only external commands are pushed.

Verification
REQ-038 Reset, then push (100, 200, draw) with ready held 1 -> x = 100 and y = 200 at E+2, draw high for exactly 1 cycle, jump stays 0.
REQ-039 Push DEPTH+1 commands while ready is held 0 -> cmd_ready = 0 after DEPTH pushes, count = DEPTH, the extra command is not accepted.
REQ-040 Queue 3 commands and toggle ready low for 4 cycles after each strobe -> exactly 3 strobes, in order, each waiting for ready to go low then high.
REQ-041 Assert reset in WAIT_ACK with count = 5 -> next cycle count = 0, busy = 0, x = y = 0, and no strobe follows.
REQ-042 With PATTERN_GEN_EN, COORD_W = 4 and pattern_en = 1 -> jumps to (0,0), (5,10), (10,4), (15,14), (4,8), wrapping modulo 16.
REQ-043 Full FIFO with simultaneous pop and cmd_valid = 1 -> push is refused that cycle (cmd_ready = 0), and count becomes DEPTH-1.

Source files
------------

// File: rtl/vector_sequencer.sv
// Command FIFO feeding a line engine through a draw/jump strobe handshake.
// Optional pattern generator enabled by defining PATTERN_GEN_EN.
module vector_sequencer #(
    parameter int unsigned COORD_W = 12,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned STEP_X  = 5,
    parameter int unsigned STEP_Y  = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [COORD_W-1:0]         cmd_x,
    input  logic [COORD_W-1:0]         cmd_y,
    input  logic                       cmd_draw,
    output logic [COORD_W-1:0]         x,
    output logic [COORD_W-1:0]         y,
    output logic                       draw,
    output logic                       jump,
    input  logic                       ready,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
`ifdef PATTERN_GEN_EN
    ,
    input  logic                       pattern_en
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 2 * COORD_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    logic [EW-1:0]      mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    state_e             state_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [COORD_W-1:0] cur_x_q;
    logic [COORD_W-1:0] cur_y_q;
    logic               cur_draw_q;
    logic               draw_q;
    logic               jump_q;

    logic               full_d;
    logic               push_d;
    logic               pop_d;
    logic [EW-1:0]      push_data_d;

`ifdef PATTERN_GEN_EN
    logic [COORD_W-1:0] px_q;
    logic [COORD_W-1:0] py_q;
    logic               gen_push_d;
`endif

    // Push source selection: external commands always win over the generator.
    always_comb begin
        full_d      = (count_q == CW'(DEPTH));
        push_d      = cmd_valid && !full_d;
        push_data_d = {cmd_x, cmd_y, cmd_draw};
`ifdef PATTERN_GEN_EN
        gen_push_d  = pattern_en && !cmd_valid && !full_d;
        if (gen_push_d) begin
            push_d      = 1'b1;
            push_data_d = {px_q, py_q, 1'b0};
        end
`endif
        pop_d       = (state_q == IDLE) && (count_q != '0) && ready;
    end

    always_ff @(posedge clk) begin
        if (push_d && !reset) begin
            mem_q[wr_ptr_q] <= push_data_d;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_d) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_d) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_d) - CW'(pop_d);
        end
    end

`ifdef PATTERN_GEN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            px_q <= '0;
            py_q <= '0;
        end else if (gen_push_d) begin
            px_q <= px_q + COORD_W'(STEP_X);
            py_q <= py_q + COORD_W'(STEP_Y);
        end
    end
`endif

    // Handshake FSM: the popped entry is staged one cycle, then presented with its strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            cur_draw_q <= 1'b0;
            draw_q     <= 1'b0;
            jump_q     <= 1'b0;
        end else begin
            draw_q <= 1'b0;
            jump_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop_d) begin
                        {cur_x_q, cur_y_q, cur_draw_q} <= mem_q[rd_ptr_q];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    x_q     <= cur_x_q;
                    y_q     <= cur_y_q;
                    draw_q  <= cur_draw_q;
                    jump_q  <= !cur_draw_q;
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!ready) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = !full_d;
    assign count     = count_q;
    assign x         = x_q;
    assign y         = y_q;
    assign draw      = draw_q;
    assign jump      = jump_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_vector_sequencer;

    localparam int unsigned W  = 12;
    localparam int unsigned D  = 16;
    localparam int unsigned CW = $clog2(D) + 1;
    localparam int unsigned SX = 5;
    localparam int unsigned SY = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_x;
    logic [W-1:0]  cmd_y;
    logic          cmd_draw;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          draw;
    logic          jump;
    logic          ready;
    logic          busy;
    logic [CW-1:0] count;
`ifdef PATTERN_GEN_EN
    logic          pattern_en;
`endif

    vector_sequencer #(.COORD_W(W), .DEPTH(D), .STEP_X(SX), .STEP_Y(SY)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_draw  (cmd_draw),
        .x         (x),
        .y         (y),
        .draw      (draw),
        .jump      (jump),
        .ready     (ready),
        .busy      (busy),
        .count     (count)
`ifdef PATTERN_GEN_EN
        ,
        .pattern_en(pattern_en)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a command queue plus the handshake rules, advanced once per rising edge.
    typedef struct packed {
        logic [W-1:0] cx;
        logic [W-1:0] cy;
        logic         cd;
    } cmd_t;

    cmd_t         mq[$];
    cmd_t         m_cur;
    int           m_phase = 0;   // 0 free, 1 strobe next, 2 await ready low, 3 await ready high
    logic [W-1:0] m_x = '0;
    logic [W-1:0] m_y = '0;
    logic         m_draw = 1'b0;
    logic         m_jump = 1'b0;
    logic [W-1:0] m_px = '0;
    logic [W-1:0] m_py = '0;

    always @(posedge clk) begin : model
        int   sz;
        bit   full;
        bit   do_push;
        cmd_t inc;
        if (reset) begin
            mq.delete();
            m_phase = 0;
            m_x = '0; m_y = '0; m_draw = 1'b0; m_jump = 1'b0;
            m_px = '0; m_py = '0;
        end else begin
            sz      = mq.size();
            full    = (sz == D);
            do_push = 1'b0;
            inc     = '0;
            if (cmd_valid && !full) begin
                do_push = 1'b1;
                inc = '{cx: cmd_x, cy: cmd_y, cd: cmd_draw};
            end
`ifdef PATTERN_GEN_EN
            else if (pattern_en && !cmd_valid && !full) begin
                do_push = 1'b1;
                inc = '{cx: m_px, cy: m_py, cd: 1'b0};
                m_px = m_px + W'(SX);
                m_py = m_py + W'(SY);
            end
`endif
            m_draw = 1'b0;
            m_jump = 1'b0;
            if (m_phase == 0) begin
                if (sz > 0 && ready) begin
                    m_cur = mq.pop_front();
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_x = m_cur.cx; m_y = m_cur.cy;
                m_draw = m_cur.cd; m_jump = !m_cur.cd;
                m_phase = 2;
            end else if (m_phase == 2) begin
                if (!ready) m_phase = 3;
            end else begin
                if (ready) m_phase = 0;
            end
            if (do_push) mq.push_back(inc);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("count",     32'(count),     32'(mq.size()));
            check("cmd_ready", 32'(cmd_ready), 32'(mq.size() != D));
            check("busy",      32'(busy),      32'(m_phase != 0));
            check("x",         32'(x),         32'(m_x));
            check("y",         32'(y),         32'(m_y));
            check("draw",      32'(draw),      32'(m_draw));
            check("jump",      32'(jump),      32'(m_jump));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_strobe(input string name, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (draw || jump) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL %s: got no strobe expected strobe within 20 cycles", name);
        end
    endtask

    initial begin
        bit seen;
        logic [W-1:0] ex [3];
        logic [W-1:0] ey [3];
        logic         ed [3];
        reset = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_draw = 1'b0; ready = 1'b1;
`ifdef PATTERN_GEN_EN
        pattern_en = 1'b0;
`endif
        repeat (3) tick();
        check_en = 1'b1;
        reset = 1'b0;
        tick();
        check("rst_count", 32'(count), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);

        // Single draw command: latency and strobe width.
        cmd_valid = 1'b1; cmd_x = W'(100); cmd_y = W'(200); cmd_draw = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("lat_e1_count", 32'(count), 1);
        tick();
        check("lat_e1_x", 32'(x), 0);
        check("lat_e1_busy", 32'(busy), 1);
        tick();
        check("lat_e2_x", 32'(x), 100);
        check("lat_e2_y", 32'(y), 200);
        check("lat_e2_draw", 32'(draw), 1);
        check("lat_e2_jump", 32'(jump), 0);
        tick();
        check("lat_e3_draw", 32'(draw), 0);
        ready = 1'b0; tick();
        ready = 1'b1; tick(); tick();
        check("lat_idle_busy", 32'(busy), 0);

        // Fill with ready low: DEPTH accepted, extra refused.
        ready = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < D; i++) begin
            cmd_x = W'($urandom); cmd_y = W'($urandom); cmd_draw = 1'($urandom);
            tick();
        end
        check("full_count", 32'(count), D);
        check("full_ready", 32'(cmd_ready), 0);
        tick();
        check("full_extra_count", 32'(count), D);

        // Full FIFO with pop and push in the same cycle.
        ready = 1'b1;
        check("fullpop_cmd_ready", 32'(cmd_ready), 0);
        tick();
        cmd_valid = 1'b0;
        check("fullpop_count", 32'(count), D - 1);
        reset = 1'b1; tick(); reset = 1'b0; tick();

        // Reset while waiting for acknowledge with five queued.
        ready = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_x = W'(i + 7); cmd_y = W'(i + 9); cmd_draw = 1'b0;
            tick();
        end
        cmd_valid = 1'b0; ready = 1'b1;
        tick(); tick();
        check("ack_count", 32'(count), 5);
        check("ack_jump", 32'(jump), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rstack_count", 32'(count), 0);
        check("rstack_busy", 32'(busy), 0);
        check("rstack_xy", 32'({x, y}), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstack_nostrobe", 32'({draw, jump}), 0);
        end

        // Three queued commands with a slow engine.
        ex = '{W'(1), W'(3), W'(5)}; ey = '{W'(2), W'(4), W'(6)}; ed = '{1'b1, 1'b0, 1'b1};
        ready = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_x = ex[i]; cmd_y = ey[i]; cmd_draw = ed[i];
            tick();
        end
        cmd_valid = 1'b0; ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_strobe("seq_strobe", seen);
            if (seen) begin
                check("seq_x", 32'(x), 32'(ex[k]));
                check("seq_y", 32'(y), 32'(ey[k]));
                check("seq_type", 32'({draw, jump}), 32'({ed[k], !ed[k]}));
            end
            ready = 1'b0; repeat (4) tick();
            ready = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            check("seq_no_extra", 32'({draw, jump}), 0);
        end

        // Randomized traffic, engine timing and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_x     = W'($urandom);
            cmd_y     = W'($urandom);
            cmd_draw  = 1'($urandom);
            ready     = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 299) == 0);
`ifdef PATTERN_GEN_EN
            pattern_en = ($urandom_range(0, 1) == 0);
`endif
            tick();
        end
        reset = 1'b0; cmd_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
